button_conditioner: RTL

- Parametrised N-channel front end for the board push-buttons.
- Replaces the per-button debounce instances and hand-written edge detectors in the top level with one block.
- Per channel: input synchroniser, debounce filter, press/release pulses, long-press detection and optional auto-repeat.
- Feeds the CPU control inputs (start, debug step, load) and any future menu/step controls.

---
 rtl/button_conditioner.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// N-channel push-button front end: synchroniser, debounce,
// press/release pulses, long-press detection and auto-repeat.
module button_conditioner #(
    parameter int                  NUM_BTNS      = 3,
    parameter int                  CTR_WIDTH     = 18,
    parameter logic [NUM_BTNS-1:0] ACTIVE_LOW    = '0,
    parameter int                  HOLD_WIDTH    = 24,
    parameter int                  LONG_CYCLES   = 12000000,
    parameter int                  REPEAT_CYCLES = 3000000,
    parameter logic [NUM_BTNS-1:0] REPEAT_EN     = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] level,
    output logic [NUM_BTNS-1:0] press,
    output logic [NUM_BTNS-1:0] release_pulse,
    output logic [NUM_BTNS-1:0] long_press,
    output logic [NUM_BTNS-1:0] repeat_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } state_e;

    localparam longint HOLD_LIM = longint'(1) << HOLD_WIDTH;

    if (LONG_CYCLES < 1 || longint'(LONG_CYCLES) >= HOLD_LIM) begin : g_bad_long
        $error("LONG_CYCLES does not fit in HOLD_WIDTH");
    end
    if (REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) >= HOLD_LIM) begin : g_bad_rep
        $error("REPEAT_CYCLES does not fit in HOLD_WIDTH");
    end

    // Thresholds are compared one early so hold never needs the extra bit.
    localparam logic [HOLD_WIDTH-1:0] LONG_M1  = HOLD_WIDTH'(LONG_CYCLES - 1);
    localparam logic [HOLD_WIDTH-1:0] REP_M1   = HOLD_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = '1;
    localparam logic [CTR_WIDTH-1:0]  CNT_MAX  = '1;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        logic                  s1_q, s1_d;
        logic                  s2_q, s2_d;
        logic [CTR_WIDTH-1:0]  cnt_q, cnt_d;
        logic                  level_q, level_d;
        logic                  press_q, press_d;
        logic                  rel_q, rel_d;
        logic                  long_q, long_d;
        logic                  rep_q, rep_d;
        logic [HOLD_WIDTH-1:0] hold_q, hold_d;
        state_e                state_q, state_d;

        // Synchroniser, debounce filter and edge pulses for this channel.
        always_comb begin
            s1_d    = btn_raw[i] ^ ACTIVE_LOW[i];
            s2_d    = s1_q;
            level_d = level_q;
            cnt_d   = '0;
            if (s2_q != level_q) begin
                if (cnt_q == CNT_MAX) begin
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            press_d = level_d & ~level_q;
            rel_d   = ~level_d & level_q;
        end

        // Hold FSM: release has priority over any threshold in the same cycle.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            long_d  = 1'b0;
            rep_d   = 1'b0;
            if (rel_d) begin
                state_d = IDLE;
                hold_d  = '0;
            end else if (press_d) begin
                state_d = PRESSED;
                hold_d  = '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        hold_d = '0;
                    end
                    PRESSED: begin
                        if (hold_q == LONG_M1) begin
                            long_d  = 1'b1;
                            rep_d   = REPEAT_EN[i];
                            state_d = HELD;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    HELD: begin
                        if (REPEAT_EN[i]) begin
                            if (hold_q == REP_M1) begin
                                rep_d  = 1'b1;
                                hold_d = '0;
                            end else begin
                                hold_d = hold_q + 1'b1;
                            end
                        end else if (hold_q != HOLD_MAX) begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                endcase
            end
        end

        // Channel state registers, cleared to not-pressed on reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                rep_q   <= 1'b0;
                hold_q  <= '0;
                state_q <= IDLE;
            end else begin
                s1_q    <= s1_d;
                s2_q    <= s2_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
                rep_q   <= rep_d;
                hold_q  <= hold_d;
                state_q <= state_d;
            end
        end

        assign level[i]         = level_q;
        assign press[i]         = press_q;
        assign release_pulse[i] = rel_q;
        assign long_press[i]    = long_q;
        assign repeat_pulse[i]  = rep_q;
    end

endmodule
